// File: rtl/maquina_monitor.sv
// -----------------------------------------------------------------------------
// maquina_monitor
//
// Passive protocol checker for the coffee-machine FSM state bus. Each cycle it
// samples state_in and start, validates the prev->cur transition against the
// legal brewing sequence, enforces a dwell limit on non-IDLE states, counts
// completed brews and reservoir fills, and latches the first violation.
//
// Optional feature macro: MAQUINA_MONITOR_HIST_EN adds the 16-bit 'hist'
// output holding the last four sampled state codes (newest in [3:0]).
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   state_in    observed FSM state code (4 bits)
//   start       observed start request
//   busy        1 while the observed FSM was outside IDLE at the last sample
//   err         sticky error flag
//   err_code    cause of first error (0 none, 1 illegal code, 2 illegal edge,
//               3 dwell timeout, 4 start missing, 5 bad first state)
//   err_prev    state_in from the cycle before the first error
//   err_cur     state_in at the first error
//   brews_done  completed brews (9->1), saturating
//   fills_done  entries into ENCHER_RESERVATORIO (3->4), saturating
//   hist        (optional) last four sampled state codes
// -----------------------------------------------------------------------------
module maquina_monitor #(
    parameter int MAX_DWELL = 4,
    parameter int COUNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         state_in,
    input  logic               start,
    output logic               busy,
    output logic               err,
    output logic [2:0]         err_code,
    output logic [3:0]         err_prev,
    output logic [3:0]         err_cur,
    output logic [COUNT_W-1:0] brews_done,
    output logic [COUNT_W-1:0] fills_done
`ifdef MAQUINA_MONITOR_HIST_EN
    ,
    output logic [15:0]        hist
`endif
);

    typedef enum logic [1:0] {
        MON_FIRST = 2'd0,
        MON_TRACK = 2'd1,
        MON_ERROR = 2'd2
    } mon_t;

    localparam logic [3:0]         ST_IDLE = 4'd1;
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    mon_t               r_mode;
    logic [3:0]         r_prev_state;
    logic               r_start_q;
    logic [3:0]         r_dwell;
    logic               r_busy;
    logic               r_err;
    logic [2:0]         r_err_code;
    logic [3:0]         r_err_prev;
    logic [3:0]         r_err_cur;
    logic [COUNT_W-1:0] r_brews;
    logic [COUNT_W-1:0] r_fills;
`ifdef MAQUINA_MONITOR_HIST_EN
    logic [15:0]        r_hist;
`endif

    logic       w_cur_legal;
    logic       w_repeat;
    logic       w_edge_ok;
    logic       w_dwell_to;
    logic [2:0] w_code;
    logic [3:0] w_dwell_next;

    assign w_cur_legal  = (state_in >= 4'd1) && (state_in <= 4'd9);
    assign w_repeat     = (state_in == r_prev_state) && (state_in != ST_IDLE);
    // The hold that would push dwell past MAX_DWELL is the offending one.
    assign w_dwell_to   = w_repeat && (r_dwell == 4'(MAX_DWELL));
    assign w_dwell_next = w_repeat ? (r_dwell + 4'd1) : 4'd0;

    // Edge shape only; the start qualification on 1->2 is checked separately
    // so it can report its own, higher-priority code.
    always_comb begin
        w_edge_ok = 1'b0;
        case (r_prev_state)
            4'd1:    w_edge_ok = (state_in == 4'd1) || (state_in == 4'd2);
            4'd2:    w_edge_ok = (state_in == 4'd3);
            4'd3:    w_edge_ok = (state_in == 4'd4) || (state_in == 4'd5);
            4'd4:    w_edge_ok = (state_in == 4'd5);
            4'd5:    w_edge_ok = (state_in == 4'd6);
            4'd6:    w_edge_ok = (state_in == 4'd7);
            4'd7:    w_edge_ok = (state_in == 4'd8);
            4'd8:    w_edge_ok = (state_in == 4'd9);
            4'd9:    w_edge_ok = (state_in == 4'd1);
            default: w_edge_ok = 1'b0;
        endcase
        if (w_repeat) begin
            w_edge_ok = 1'b1;
        end
    end

    // Error classification in priority order.
    always_comb begin
        w_code = 3'd0;
        if (!w_cur_legal) begin
            w_code = 3'd1;
        end else if (r_mode == MON_FIRST) begin
            w_code = (state_in != ST_IDLE) ? 3'd5 : 3'd0;
        end else if ((r_prev_state == 4'd1) && (state_in == 4'd2) && !r_start_q) begin
            w_code = 3'd4;
        end else if (!w_edge_ok) begin
            w_code = 3'd2;
        end else if (w_dwell_to) begin
            w_code = 3'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= MON_FIRST;
            r_prev_state <= 4'd0;
            r_start_q    <= 1'b0;
            r_dwell      <= 4'd0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 3'd0;
            r_err_prev   <= 4'd0;
            r_err_cur    <= 4'd0;
            r_brews      <= '0;
            r_fills      <= '0;
`ifdef MAQUINA_MONITOR_HIST_EN
            r_hist       <= 16'd0;
`endif
        end else begin
            r_start_q    <= start;
            r_prev_state <= state_in;
            r_busy       <= (state_in != ST_IDLE);
            case (r_mode)
                MON_FIRST, MON_TRACK: begin
`ifdef MAQUINA_MONITOR_HIST_EN
                    r_hist <= {r_hist[11:0], state_in};
`endif
                    if (w_code != 3'd0) begin
                        r_err      <= 1'b1;
                        r_err_code <= w_code;
                        r_err_prev <= r_prev_state;
                        r_err_cur  <= state_in;
                        r_mode     <= MON_ERROR;
                    end else begin
                        r_mode  <= MON_TRACK;
                        r_dwell <= w_dwell_next;
                        if ((r_mode == MON_TRACK) && (r_prev_state == 4'd9) &&
                            (state_in == 4'd1) && (r_brews != '1)) begin
                            r_brews <= r_brews + CNT_ONE;
                        end
                        if ((r_mode == MON_TRACK) && (r_prev_state == 4'd3) &&
                            (state_in == 4'd4) && (r_fills != '1)) begin
                            r_fills <= r_fills + CNT_ONE;
                        end
                    end
                end
                default: begin
                    // Terminal until reset: error capture and counters frozen.
                    r_mode <= MON_ERROR;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign err_prev   = r_err_prev;
    assign err_cur    = r_err_cur;
    assign brews_done = r_brews;
    assign fills_done = r_fills;
`ifdef MAQUINA_MONITOR_HIST_EN
    assign hist       = r_hist;
`endif

endmodule

// File: tb/tb_maquina_monitor.sv
module tb_maquina_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] state_in = 4'd1;
    logic       start = 1'b0;
    logic       busy;
    logic       err;
    logic [2:0] err_code;
    logic [3:0] err_prev;
    logic [3:0] err_cur;
    logic [7:0] brews_done;
    logic [7:0] fills_done;
`ifdef MAQUINA_MONITOR_HIST_EN
    logic [15:0] hist;
`endif

    maquina_monitor #(.MAX_DWELL(4), .COUNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state_in   (state_in),
        .start      (start),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code),
        .err_prev   (err_prev),
        .err_cur    (err_cur),
        .brews_done (brews_done),
        .fills_done (fills_done)
`ifdef MAQUINA_MONITOR_HIST_EN
        ,
        .hist       (hist)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       err;
        logic [2:0] code;
        logic [3:0] prev;
        logic [3:0] cur;
        logic [7:0] brews;
        logic [7:0] fills;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;

    // Expected outputs after the next sample; scenarios edit these by hand.
    logic       e_err = 1'b0;
    logic [2:0] e_code = 3'd0;
    logic [3:0] e_prev = 4'd0;
    logic [3:0] e_cur = 4'd0;
    logic [7:0] e_brews = 8'd0;
    logic [7:0] e_fills = 8'd0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_err(input logic [2:0] c, input logic [3:0] p, input logic [3:0] cu);
        e_err  = 1'b1;
        e_code = c;
        e_prev = p;
        e_cur  = cu;
    endtask

    // Called at a negedge: drive one sample, queue its expected outputs.
    task automatic step(input logic [3:0] st, input logic s, input logic e_busy);
        exp_t x;
        state_in = st;
        start    = s;
        x.busy   = e_busy;
        x.err    = e_err;
        x.code   = e_code;
        x.prev   = e_prev;
        x.cur    = e_cur;
        x.brews  = e_brews;
        x.fills  = e_fills;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("queue_drain", q.size(), 0);
        q.delete();
    endtask

    // Asserts reset mid-cycle, checks outputs clear without a clock edge,
    // releases at the next negedge and leaves the bench there.
    task automatic do_reset();
        drain();
        @(negedge clk);
        rst_n    = 1'b0;
        state_in = 4'd1;
        start    = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_prev", err_prev, 0);
        chk("rst_cur", err_cur, 0);
        chk("rst_brews", brews_done, 0);
        chk("rst_fills", fills_done, 0);
        e_err = 1'b0; e_code = 3'd0; e_prev = 4'd0; e_cur = 4'd0;
        e_brews = 8'd0; e_fills = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares registered outputs just after each sampling edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                n_txn++;
                $display("txn %0d: st=%0d busy=%0b err=%0b code=%0d prev=%0d cur=%0d brews=%0d fills=%0d",
                         n_txn, state_in, busy, err, err_code, err_prev, err_cur, brews_done, fills_done);
                chk("busy", busy, x.busy);
                chk("err", err, x.err);
                chk("err_code", err_code, x.code);
                chk("err_prev", err_prev, x.prev);
                chk("err_cur", err_cur, x.cur);
                chk("brews_done", brews_done, x.brews);
                chk("fills_done", fills_done, x.fills);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        // Full brew with reservoir fill.
        do_reset();
        step(4'd1, 1'b1, 1'b0);
        step(4'd1, 1'b1, 1'b0);
        step(4'd1, 1'b1, 1'b0);
        step(4'd2, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b1);
        e_fills = 8'd1;
        step(4'd4, 1'b0, 1'b1);
        step(4'd5, 1'b0, 1'b1);
        step(4'd6, 1'b0, 1'b1);
        step(4'd7, 1'b0, 1'b1);
        step(4'd8, 1'b0, 1'b1);
        step(4'd9, 1'b0, 1'b1);
        e_brews = 8'd1;
        step(4'd1, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0);

        // Skip fill (3->5) and hold 7 for exactly MAX_DWELL repeats.
        do_reset();
        step(4'd1, 1'b1, 1'b0);
        step(4'd2, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b1);
        step(4'd5, 1'b0, 1'b1);
        step(4'd6, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(4'd7, 1'b0, 1'b1);
        step(4'd8, 1'b0, 1'b1);
        step(4'd9, 1'b0, 1'b1);
        e_brews = 8'd1;
        step(4'd1, 1'b0, 1'b0);

        // 1->2 without start; later activity must not move counters.
        do_reset();
        step(4'd1, 1'b0, 1'b0);
        set_err(3'd4, 4'd1, 4'd2);
        step(4'd2, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b1);
        step(4'd4, 1'b0, 1'b1);
        step(4'd5, 1'b0, 1'b1);
        step(4'd1, 1'b0, 1'b0);

        // Illegal edge 5->9, then a later illegal code is ignored.
        do_reset();
        step(4'd1, 1'b1, 1'b0);
        step(4'd2, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b1);
        step(4'd5, 1'b0, 1'b1);
        set_err(3'd2, 4'd5, 4'd9);
        step(4'd9, 1'b0, 1'b1);
        step(4'd12, 1'b0, 1'b1);
        step(4'd1, 1'b0, 1'b0);

        // Dwell timeout on the fifth repeat of 7.
        do_reset();
        step(4'd1, 1'b1, 1'b0);
        step(4'd2, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b1);
        step(4'd5, 1'b0, 1'b1);
        step(4'd6, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(4'd7, 1'b0, 1'b1);
        set_err(3'd3, 4'd7, 4'd7);
        step(4'd7, 1'b0, 1'b1);
        step(4'd8, 1'b0, 1'b1);

        // Non-IDLE first sample.
        do_reset();
        set_err(3'd5, 4'd0, 4'd7);
        step(4'd7, 1'b0, 1'b1);
        step(4'd8, 1'b0, 1'b1);

        // Illegal code mid-run.
        do_reset();
        step(4'd1, 1'b1, 1'b0);
        step(4'd2, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b1);
        set_err(3'd1, 4'd3, 4'd12);
        step(4'd12, 1'b0, 1'b1);
        step(4'd1, 1'b0, 1'b0);

        // Illegal code as first sample outranks bad first state.
        do_reset();
        set_err(3'd1, 4'd0, 4'd0);
        step(4'd0, 1'b0, 1'b1);

        // 256 brews: counter saturates at 255.
        do_reset();
        step(4'd1, 1'b1, 1'b0);
        for (int k = 1; k <= 256; k++) begin
            step(4'd2, 1'b0, 1'b1);
            step(4'd3, 1'b0, 1'b1);
            step(4'd5, 1'b0, 1'b1);
            step(4'd6, 1'b0, 1'b1);
            step(4'd7, 1'b0, 1'b1);
            step(4'd8, 1'b0, 1'b1);
            step(4'd9, 1'b0, 1'b1);
            e_brews = (k > 255) ? 8'd255 : 8'(k);
            step(4'd1, 1'b1, 1'b0);
        end
        step(4'd2, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b1);
        step(4'd5, 1'b0, 1'b1);

        // Reset mid-brew, then a clean restart from IDLE.
        do_reset();
        step(4'd1, 1'b1, 1'b0);
        step(4'd2, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b1);
        e_fills = 8'd1;
        step(4'd4, 1'b0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
